uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared defaults and FSM encoding for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int DEF_NREQ         = 4;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_LOCK_TIMEOUT = 1023;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping at NREQ-1.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    int cand;
    cand    = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req[IDX_W'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer among NREQ requesters with message-level locking.
// Grant -> handshake -> registered tx_start takes 2 cycles; one byte in flight at a time.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  NREQ         = DEF_NREQ,
  parameter int  DATA_W       = DEF_DATA_W,
  parameter int  LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  localparam int IDX_W        = idx_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_id
);

  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic              grant_valid_q, grant_valid_d;
  logic              last_q, last_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic [IDX_W-1:0]  rr_idx;
  logic              rr_any;
  logic              owner_vld;
  logic              hs;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == IDX_W'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_last = req_last[i];
      end
    end
  end

  assign owner_vld = req_valid[grant_id_q];
  // Gated by rst so a reset landing in ISSUE never looks like an accepted byte.
  assign hs        = (state_q == S_ISSUE) && owner_vld && !tx_busy && !rst;

  always_comb begin
    req_ready             = '0;
    req_ready[grant_id_q] = hs;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    tmo_d         = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (!tx_busy && rr_any) begin
          grant_id_d    = rr_idx;
          grant_valid_d = 1'b1;
          tmo_d         = '0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          tx_start_d = 1'b1;
          tx_data_d  = sel_data;
          last_d     = sel_last;
          tmo_d      = '0;
          state_d    = S_WAIT;
        end else if (!owner_vld) begin
          // A stalled owner only keeps the lock for LOCK_TIMEOUT idle cycles.
          if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
            grant_valid_d = 1'b0;
            ptr_d         = grant_id_q;
            tmo_d         = '0;
            state_d       = S_IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          if (last_q) begin
            ptr_d         = grant_id_q;
            grant_valid_d = 1'b0;
            state_d       = S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= IDX_W'(NREQ - 1);
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      last_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      last_q        <= last_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      tmo_q         <= tmo_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: message-level round-robin model, serializer model,
// directed corner cases followed by randomized traffic.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int LT   = 20;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } byte_t;

  typedef struct {
    int         id;
    logic [7:0] d;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [DW-1:0]     tx_data;
  logic              tx_busy;
  logic              tx_done;
  logic              grant_valid;
  logic [1:0]        grant_id;

  uart_tx_arbiter #(
    .NREQ         (NREQ),
    .DATA_W       (DW),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  byte_t rq[NREQ][$];
  exp_t  sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr;
  int ser_cnt  = 0;
  int ser_lo   = 3;
  int ser_hi   = 6;
  int stall_run = 0;
  bit stall_en = 0;
  bit arm_r1   = 0;
  logic [NREQ-1:0] rdy_s = '0;
  logic            st_s  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every output the DUT launches must match the next byte the model expects.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rdy_onehot", ((req_ready == '0) ||
          (grant_valid && req_ready == (4'(1) << grant_id))), 1);
      if (tx_start) begin
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("tx_data", tx_data, e.d);
          chk("tx_owner", grant_id, e.id);
        end
      end
    end
  end

  // Message-level round robin: whole messages go out, the winner becomes the new pointer.
  task automatic predict();
    byte_t c[NREQ][$];
    byte_t b;
    exp_t  e;
    int    win;
    for (int i = 0; i < NREQ; i++) c[i] = rq[i];
    win = 0;
    while (win >= 0) begin
      win = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && c[idx].size() > 0) win = idx;
      end
      if (win >= 0) begin
        do begin
          b = c[win].pop_front();
          e.id = win;
          e.d  = b.d;
          sb.push_back(e);
        end while (!b.l && c[win].size() > 0);
        m_ptr = win;
      end
    end
  endtask

  // One clock: apply handshakes and serializer progress after the edge, sample at negedge.
  task automatic step();
    bit any_stall;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (rdy_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    tx_done = 1'b0;
    if (ser_cnt > 0) begin
      ser_cnt--;
      if (ser_cnt == 0) begin
        tx_busy = 1'b0;
        tx_done = 1'b1;
        if (arm_r1) begin
          byte_t nb;
          nb.d = 8'h71;
          nb.l = 1'b1;
          rq[1].push_back(nb);
          arm_r1 = 0;
        end
      end
    end
    if (st_s) begin
      ser_cnt = $urandom_range(ser_hi, ser_lo);
      tx_busy = 1'b1;
    end
    any_stall = 0;
    for (int i = 0; i < NREQ; i++) begin
      bit stall;
      stall = 0;
      if (stall_en && grant_valid && int'(grant_id) == i && stall_run < 4 &&
          $urandom_range(2, 0) == 0) stall = 1;
      if (stall) any_stall = 1;
      req_valid[i] = (rq[i].size() > 0) && !stall;
      req_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0].d : 8'h00;
      req_last[i] = (rq[i].size() > 0) ? rq[i][0].l : 1'b0;
    end
    stall_run = any_stall ? stall_run + 1 : 0;
    @(negedge clk);
    rdy_s = req_ready;
    st_s  = tx_start;
  endtask

  function automatic bit qs_empty();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (!(sb.size() == 0 && !tx_busy && !grant_valid && qs_empty()) && n < max) begin
      step();
      n++;
    end
    chk("drain", n < max, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_ptr = NREQ - 1;
  endtask

  task automatic push_rq(input int id, input logic [7:0] d, input logic l);
    byte_t b;
    b.d = d;
    b.l = l;
    rq[id].push_back(b);
  endtask

  task automatic push_sb(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    sb.push_back(e);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    m_ptr     = NREQ - 1;
    do_reset();
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);

    // Single request: grant, handshake at cycle 1, tx_start at cycle 2.
    push_rq(0, 8'h41, 1'b1);
    predict();
    step();
    chk("t1_c0_rdy", req_ready, 4'b0000);
    chk("t1_c0_gv", grant_valid, 0);
    step();
    chk("t1_c1_gv", grant_valid, 1);
    chk("t1_c1_gid", grant_id, 0);
    chk("t1_c1_rdy", req_ready, 4'b0001);
    step();
    chk("t1_c2_start", tx_start, 1);
    chk("t1_c2_data", tx_data, 8'h41);
    chk("t1_c2_rdy", req_ready, 4'b0000);
    n = 0;
    while (!tx_done && n < 50) begin
      step();
      n++;
    end
    chk("t1_done_seen", n < 50, 1);
    chk("t1_gv_in_done", grant_valid, 1);
    step();
    chk("t1_gv_clear", grant_valid, 0);
    wait_drain(100);

    // Round robin from reset: 0,1,2,3 then 0 again.
    do_reset();
    push_rq(0, 8'hA0, 1'b1);
    push_rq(1, 8'hA1, 1'b1);
    push_rq(2, 8'hA2, 1'b1);
    push_rq(3, 8'hA3, 1'b1);
    push_rq(0, 8'hA4, 1'b1);
    predict();
    wait_drain(400);

    // Message lock: requester 2 sends two bytes while 0 waits.
    push_rq(2, 8'h48, 1'b0);
    push_rq(2, 8'h49, 1'b1);
    push_rq(0, 8'h30, 1'b1);
    predict();
    wait_drain(400);

    // Timeout: requester 1 stalls mid-message, 2 takes over once the lock expires.
    push_rq(1, 8'h31, 1'b0);
    push_rq(2, 8'h52, 1'b1);
    push_sb(1, 8'h31);
    n = 0;
    while (!(tx_done && grant_valid) && n < 100) begin
      step();
      n++;
    end
    chk("t4_done_seen", n < 100, 1);
    n = 0;
    step();
    while (grant_valid && n < 500) begin
      chk("t4_locked_id", grant_id, 1);
      n++;
      step();
    end
    chk("t4_lock_cycles", n, LT);
    push_sb(2, 8'h52);
    m_ptr = 2;
    step();
    chk("t4_next_gv", grant_valid, 1);
    chk("t4_next_gid", grant_id, 2);
    wait_drain(400);

    // Reset during WAIT while the serializer is still shifting.
    ser_lo = 12;
    ser_hi = 12;
    push_rq(3, 8'h55, 1'b0);
    push_rq(3, 8'h66, 1'b1);
    push_sb(3, 8'h55);
    n = 0;
    while (!tx_busy && n < 20) begin
      step();
      n++;
    end
    chk("t5_busy_seen", n < 20, 1);
    rst = 1'b1;
    step();
    chk("t5_gv", grant_valid, 0);
    chk("t5_gid", grant_id, 0);
    chk("t5_rdy", req_ready, 0);
    chk("t5_start", tx_start, 0);
    chk("t5_data", tx_data, 0);
    step();
    rst = 1'b0;
    push_sb(3, 8'h66);
    m_ptr = 3;
    n = 0;
    while (tx_busy && n < 40) begin
      chk("t5_no_start", tx_start, 0);
      chk("t5_no_grant", grant_valid, 0);
      step();
      n++;
    end
    chk("t5_busy_end", n < 40, 1);
    ser_lo = 3;
    ser_hi = 6;
    wait_drain(400);

    // tx_done coincides with requester 1 becoming valid: no same-cycle bypass.
    push_rq(0, 8'h60, 1'b1);
    predict();
    arm_r1 = 1;
    n = 0;
    while (!tx_done && n < 100) begin
      step();
      n++;
    end
    chk("t6_done_seen", n < 100, 1);
    push_sb(1, 8'h71);
    m_ptr = 1;
    chk("t6_c0_gv", grant_valid, 1);
    chk("t6_c0_rdy", req_ready, 0);
    step();
    chk("t6_c1_gv", grant_valid, 0);
    chk("t6_c1_rdy", req_ready, 0);
    step();
    chk("t6_c2_gv", grant_valid, 1);
    chk("t6_c2_gid", grant_id, 1);
    chk("t6_c2_rdy", req_ready, 4'b0010);
    step();
    chk("t6_c3_start", tx_start, 1);
    chk("t6_c3_data", tx_data, 8'h71);
    wait_drain(400);

    // Random messages with short owner stalls and varying frame lengths.
    stall_en = 1;
    ser_lo = 1;
    ser_hi = 5;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        int nm;
        nm = $urandom_range(3, 1);
        for (int m = 0; m < nm; m++) begin
          int len;
          len = $urandom_range(3, 1);
          for (int b = 0; b < len; b++)
            push_rq(i, 8'($urandom), (b == len - 1));
        end
      end
      predict();
      wait_drain(4000);
    end
    stall_en = 0;

    chk("sb_final", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
